// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   owner_e  - owner register encoding (idle / CPU / DMA)
//   BURST_W  - width of the DMA burst-lock counter (holds 0..15)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } owner_e;

  localparam int BURST_W = 4;

endpackage

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
// Combinational next-owner selection for the data-memory arbiter.
// Ports:
//   i_cpu_req, i_dma_req - live request lines
//   i_state              - current owner
//   i_last               - most recent completed owner, including this cycle
//   i_dma_lock           - DMA asks to keep ownership while the CPU waits
//   i_burst_cnt          - locked DMA accesses already granted over the CPU
//   o_next               - owner for the next cycle
//   o_burst_inc          - next grant is a locked DMA grant (counter steps)
// -----------------------------------------------------------------------------
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               i_cpu_req,
  input  logic               i_dma_req,
  input  owner_e             i_state,
  input  owner_e             i_last,
  input  logic               i_dma_lock,
  input  logic [BURST_W-1:0] i_burst_cnt,
  output owner_e             o_next,
  output logic               o_burst_inc
);

  localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

  always_comb begin
    o_next      = ST_IDLE;
    o_burst_inc = 1'b0;
    case ({i_cpu_req, i_dma_req})
      2'b00: o_next = ST_IDLE;
      2'b10: o_next = ST_CPU;
      2'b01: o_next = ST_DMA;
      default: begin
        // Contention: a locking DMA owner may hold on for a bounded number
        // of extra accesses, otherwise fall back to round-robin.
        if (i_state == ST_DMA && i_dma_lock && i_burst_cnt < MAX_CNT) begin
          o_next      = ST_DMA;
          o_burst_inc = 1'b1;
        end else begin
          o_next = (i_last == ST_CPU) ? ST_DMA : ST_CPU;
        end
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between the CPU memory stage and a
// DMA/loader port. A registered owner (idle / CPU / DMA) selects which
// requester drives the memory; the owner's access completes in the cycle it
// owns the memory with its request raised.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      - CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready       - CPU completion and read data
//   cpu_stall                  - CPU request pending and not completing
//   dma_req/we/addr/wdata      - DMA request, held until dma_ready
//   dma_rdata, dma_ready       - DMA completion and read data
//   dma_lock                   - DMA requests bounded burst ownership
//   mem_we/addr/wdata          - memory write enable, address, write data
//   mem_rdata                  - memory asynchronous read data
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  input  logic              dma_lock,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e             r_state;
  owner_e             r_last;
  logic [BURST_W-1:0] r_burst_cnt;

  owner_e             w_next;
  owner_e             w_last_eff;
  logic               w_burst_inc;
  logic [BURST_W-1:0] w_burst_next;
  logic               w_cpu_ready;
  logic               w_dma_ready;
  logic               w_mem_we;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0]  w_mem_wdata;

  // Every output is held at zero while reset is high, so an access in flight
  // when reset arrives is dropped without touching memory.
  assign w_cpu_ready = ~reset & (r_state == ST_CPU) & cpu_req;
  assign w_dma_ready = ~reset & (r_state == ST_DMA) & dma_req;

  // The access completing this cycle already counts as "last" for the
  // round-robin decision; otherwise a continuously requesting owner would
  // win the tie a second time before its register caught up.
  assign w_last_eff = w_cpu_ready ? ST_CPU : (w_dma_ready ? ST_DMA : r_last);

  dmem_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .i_cpu_req   (cpu_req),
    .i_dma_req   (dma_req),
    .i_state     (r_state),
    .i_last      (w_last_eff),
    .i_dma_lock  (dma_lock),
    .i_burst_cnt (r_burst_cnt),
    .o_next      (w_next),
    .o_burst_inc (w_burst_inc)
  );

  always_comb begin
    w_burst_next = r_burst_cnt;
    if (w_next != ST_DMA) begin
      w_burst_next = '0;
    end else if (w_burst_inc) begin
      if (r_burst_cnt != '1) begin
        w_burst_next = r_burst_cnt + 1'b1;
      end
    end else if (w_dma_ready && !cpu_req) begin
      // DMA served with nobody waiting: the lock window starts afresh.
      w_burst_next = '0;
    end
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      ST_CPU: begin
        w_mem_we    = cpu_we & cpu_req;
        w_mem_addr  = cpu_addr;
        w_mem_wdata = cpu_wdata;
      end
      ST_DMA: begin
        w_mem_we    = dma_we & dma_req;
        w_mem_addr  = dma_addr;
        w_mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  assign mem_we    = ~reset & w_mem_we;
  assign mem_addr  = reset ? '0 : w_mem_addr;
  assign mem_wdata = reset ? '0 : w_mem_wdata;

  assign cpu_ready = w_cpu_ready;
  assign dma_ready = w_dma_ready;
  assign cpu_rdata = w_cpu_ready ? mem_rdata : '0;
  assign dma_rdata = w_dma_ready ? mem_rdata : '0;
  assign cpu_stall = ~reset & cpu_req & ~w_cpu_ready;

  // Owner register. last resets to DMA so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last      <= ST_DMA;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_last      <= w_last_eff;
      r_burst_cnt <= w_burst_next;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Drives dmem_arbiter against a 256x8 memory model. Every issued access pushes
// its expected completion cycle and read data onto a per-port queue; each
// ready pulse pops and compares. Directed checks cover stall, reset and
// no-access cycles.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_ready, cpu_stall;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       dma_req, dma_we, dma_ready, dma_lock;
  logic [7:0] dma_addr, dma_wdata, dma_rdata;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic       preload;
  logic [7:0] mem [256];

  typedef struct {
    int         cyc;
    logic       we;
    logic [7:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t dma_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_ready (dma_ready),
    .dma_lock  (dma_lock),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'h4A;
  endfunction

  // Memory model: asynchronous read, write at the edge ending the cycle.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_cpu(input int c, input logic we, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.we = we; e.data = d;
    cpu_q.push_back(e);
  endtask

  task automatic push_dma(input int c, input logic we, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.we = we; e.data = d;
    dma_q.push_back(e);
  endtask

  // Waits for the falling edge and retires any completing access.
  task automatic mon();
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (cpu_ready) begin
        $display("cyc %0d cpu %s addr %02h data %02h", cyc, cpu_we ? "WR" : "RD",
                 cpu_addr, cpu_we ? cpu_wdata : cpu_rdata);
        chk("cpu_expected", cpu_q.size() != 0, 1);
        if (cpu_q.size() != 0) begin
          e = cpu_q.pop_front();
          chk("cpu_cycle", cyc, e.cyc);
          if (!e.we) chk("cpu_rdata", cpu_rdata, e.data);
        end
      end
      if (dma_ready) begin
        $display("cyc %0d dma %s addr %02h data %02h", cyc, dma_we ? "WR" : "RD",
                 dma_addr, dma_we ? dma_wdata : dma_rdata);
        chk("dma_expected", dma_q.size() != 0, 1);
        if (dma_q.size() != 0) begin
          e = dma_q.pop_front();
          chk("dma_cycle", cyc, e.cyc);
          if (!e.we) chk("dma_rdata", dma_rdata, e.data);
        end
      end
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      mon();
      chk("rst_cpu_ready", cpu_ready, 0);
      chk("rst_cpu_stall", cpu_stall, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      nxt();
    end
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int stalls;
    reset = 1'b1; preload = 1'b1;
    // CPU read of 0x10 already requested while reset is high.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
    dma_lock = 1'b0;
    @(posedge clk); #1;
    preload = 1'b0;

    // Reset, then CPU read through the IDLE path: one wait cycle.
    do_reset(3);
    base = cyc;
    push_cpu(base + 1, 1'b0, 8'h5A);
    mon();
    chk("t1_stall", cpu_stall, 1);
    chk("t1_ready_wait", cpu_ready, 0);
    chk("t1_rdata_idle", cpu_rdata, 0);
    nxt();
    mon();
    chk("t1_ready", cpu_ready, 1);
    chk("t1_mem_we", mem_we, 0);
    nxt();
    cpu_req = 1'b0;
    mon(); nxt();

    // CPU write and DMA read of the same address issued together.
    do_reset(2);
    base = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'hC3;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
    push_cpu(base + 1, 1'b1, 8'h00);
    push_dma(base + 2, 1'b0, 8'hC3);
    mon(); nxt();
    mon();
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_addr", mem_addr, 8'h20);
    chk("t2_mem_wdata", mem_wdata, 8'hC3);
    nxt();
    cpu_req = 1'b0;
    mon(); nxt();
    dma_req = 1'b0;
    mon(); nxt();

    // Both requesting without lock: strict alternation, no idle cycles.
    base = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
    for (int k = 0; k < 4; k++) begin
      push_cpu(base + 1 + 2 * k, 1'b0, 8'h5A);
      push_dma(base + 2 + 2 * k, 1'b0, 8'hC3);
    end
    for (int i = 0; i < 9; i++) begin
      if (i == 8) cpu_req = 1'b0;
      mon();
      if (i > 0) chk("t3_access_each_cycle", cpu_ready | dma_ready, 1);
      nxt();
    end
    dma_req = 1'b0;
    mon(); nxt();
    mon(); nxt();

    // CPU-only write leaves last=CPU, so DMA wins the next tie and bursts.
    base = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h77;
    push_cpu(base + 1, 1'b1, 8'h00);
    mon(); nxt();
    mon(); nxt();
    cpu_req = 1'b0;
    mon(); nxt();
    base = cyc;
    stalls = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h40; dma_lock = 1'b1;
    for (int k = 1; k <= 5; k++) push_dma(base + k, 1'b0, 8'h77);
    push_cpu(base + 6, 1'b0, 8'h5A);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) dma_req = 1'b0;
      mon();
      chk("t4_stall", cpu_stall, (i < 6) ? 1 : 0);
      if (cpu_stall) stalls++;
      nxt();
    end
    chk("t4_stall_len", stalls, 6);
    cpu_req = 1'b0; dma_lock = 1'b0;
    mon(); nxt();
    mon(); nxt();

    // Reset lands on a granted CPU write: no write, owner back to IDLE.
    base = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'hEE;
    mon(); nxt();
    reset = 1'b1;
    mon();
    chk("t5_mem_we", mem_we, 0);
    chk("t5_ready", cpu_ready, 0);
    nxt();
    reset = 1'b0;
    cpu_we = 1'b0;
    push_cpu(base + 3, 1'b0, init_val(8'h30));
    mon();
    chk("t5_ready_idle", cpu_ready, 0);
    chk("t5_mem30", mem[8'h30], init_val(8'h30));
    nxt();
    mon(); nxt();
    cpu_req = 1'b0;
    mon(); nxt();
    mon(); nxt();

    // DMA owner drops its request while the CPU waits: one empty cycle.
    base = cyc;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h50; dma_wdata = 8'h99;
    push_dma(base + 1, 1'b1, 8'h00);
    mon(); nxt();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h50; dma_lock = 1'b1;
    mon();
    chk("t6_stall", cpu_stall, 1);
    nxt();
    dma_req = 1'b0;
    push_cpu(base + 3, 1'b0, 8'h99);
    mon();
    chk("t6_mem_we", mem_we, 0);
    chk("t6_cpu_ready_gap", cpu_ready, 0);
    chk("t6_dma_ready_gap", dma_ready, 0);
    nxt();
    mon();
    chk("t6_cpu_ready", cpu_ready, 1);
    nxt();
    cpu_req = 1'b0; dma_lock = 1'b0; dma_we = 1'b0;
    mon(); nxt();
    mon(); nxt();

    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("dma_q_drained", dma_q.size(), 0);
    chk("mem20", mem[8'h20], 8'hC3);
    chk("mem40", mem[8'h40], 8'h77);
    chk("mem50", mem[8'h50], 8'h99);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
